// File: rtl/bin2dec_pkg.sv
// Shared types and helpers for the bin2dec scheduler: FSM state encoding,
// digit width and a clog2 helper that never returns a zero width.
package bin2dec_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STROBE  = 2'd1,
    S_COLLECT = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;

  // Width needed to index n items, at least 1 bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bin2dec_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i in index order.
// Purely combinational; the owner registers the pointer.
module rr_arbiter
  import bin2dec_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = clog2w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_onehot_o,
  output logic [IW-1:0]   grant_idx_o,
  output logic            any_o
);

  logic found_s;
  int   k_s;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    found_s     = 1'b0;
    k_s         = 0;
    grant_idx_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      k_s         = (int'(ptr_i) + i) % NREQ;
      grant_idx_o = (!found_s && req_i[k_s]) ? IW'(k_s) : grant_idx_o;
      found_s     = found_s | req_i[k_s];
    end
    any_o          = found_s;
    grant_onehot_o = found_s ? (NREQ'(1) << grant_idx_o) : '0;
  end

endmodule

// File: rtl/bin2dec_sched.sv
// Shares one bin2dec converter between NREQ requesters, buffers its LSB-first
// digits and replays them MSB-first on a valid/ready stream tagged with the owner id.
module bin2dec_sched
  import bin2dec_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NREQ       = 4,
  parameter int MAX_DIGITS = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ*WIDTH-1:0]    i_bin,
  output logic [NREQ-1:0]          o_ack,
  output logic [WIDTH-1:0]         o_cv_bin,
  output logic                     o_cv_stb,
  input  logic [DIGIT_W-1:0]       i_cv_digit,
  input  logic                     i_cv_dig_rd,
  input  logic                     i_cv_conv_rd,
  output logic [DIGIT_W-1:0]       o_dig,
  output logic                     o_dig_valid,
  input  logic                     i_dig_ready,
  output logic                     o_dig_last,
  output logic [clog2w(NREQ)-1:0]  o_dig_id,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int IW = clog2w(NREQ);
  localparam int CW = clog2w(MAX_DIGITS + 1);
  localparam int TW = clog2w(TIMEOUT + 1);

  state_t             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      grant_q;
  logic [WIDTH-1:0]   operand_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      idx_q;
  logic [TW-1:0]      timer_q;
  logic [DIGIT_W-1:0] buf_q [MAX_DIGITS];
  logic [NREQ-1:0]    ack_q;
  logic               cv_stb_q;
  logic [DIGIT_W-1:0] dig_q;
  logic               dig_valid_q;
  logic               dig_last_q;
  logic [IW-1:0]      dig_id_q;
  logic               err_q;

  logic [NREQ-1:0]    arb_onehot_s;
  logic [IW-1:0]      arb_idx_s;
  logic               arb_any_s;

  logic               wr_en_d;
  logic [CW-1:0]      cnt_d;
  logic [DIGIT_W-1:0] top_dig_d;
  logic [CW-1:0]      idx_m1_d;
  logic [DIGIT_W-1:0] nxt_dig_d;
  logic [IW-1:0]      ptr_d;
  logic [WIDTH-1:0]   arb_bin_d;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i          (i_req),
    .ptr_i          (ptr_q),
    .grant_onehot_o (arb_onehot_s),
    .grant_idx_o    (arb_idx_s),
    .any_o          (arb_any_s)
  );

  // Collect-side write enable, post-write count and the digit that becomes MSB on EMIT entry.
  always_comb begin
    wr_en_d   = i_cv_dig_rd & (count_q < CW'(MAX_DIGITS));
    cnt_d     = count_q + CW'(wr_en_d);
    top_dig_d = '0;
    if (wr_en_d) begin
      top_dig_d = i_cv_digit;
    end else if (count_q != '0) begin
      top_dig_d = buf_q[count_q - CW'(1)];
    end else begin
      top_dig_d = '0;
    end
    idx_m1_d  = idx_q - CW'(1);
    nxt_dig_d = (idx_q != '0) ? buf_q[idx_m1_d] : '0;
    ptr_d     = (arb_idx_s == IW'(NREQ - 1)) ? '0 : arb_idx_s + IW'(1);
    arb_bin_d = i_bin[arb_idx_s*WIDTH +: WIDTH];
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      operand_q   <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      ack_q       <= '0;
      cv_stb_q    <= 1'b0;
      dig_q       <= '0;
      dig_valid_q <= 1'b0;
      dig_last_q  <= 1'b0;
      dig_id_q    <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      ack_q    <= '0;
      cv_stb_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_any_s) begin
            state_q   <= S_STROBE;
            grant_q   <= arb_idx_s;
            ptr_q     <= ptr_d;
            operand_q <= arb_bin_d;
            ack_q     <= arb_onehot_s;
            cv_stb_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_STROBE: begin
          count_q <= '0;
          timer_q <= TW'(TIMEOUT);
          state_q <= S_COLLECT;
        end
        S_COLLECT: begin
          if (wr_en_d) begin
            buf_q[count_q] <= i_cv_digit;
          end else begin
            buf_q[count_q] <= buf_q[count_q];
          end
          count_q <= cnt_d;
          // A digit beyond the buffer depth is dropped but flagged.
          if (i_cv_dig_rd && !wr_en_d) begin
            err_q <= 1'b1;
          end else begin
            err_q <= err_q;
          end
          if (i_cv_conv_rd) begin
            if (cnt_d == '0) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q     <= S_EMIT;
              idx_q       <= cnt_d - CW'(1);
              dig_q       <= top_dig_d;
              dig_valid_q <= 1'b1;
              dig_last_q  <= (cnt_d == CW'(1));
              dig_id_q    <= grant_q;
            end
          end else if (timer_q == '0) begin
            err_q   <= 1'b1;
            count_q <= '0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_EMIT: begin
          if (i_dig_ready) begin
            if (idx_q == '0) begin
              dig_valid_q <= 1'b0;
              dig_last_q  <= 1'b0;
              dig_q       <= '0;
              dig_id_q    <= '0;
              count_q     <= '0;
              state_q     <= S_IDLE;
            end else begin
              idx_q      <= idx_m1_d;
              dig_q      <= nxt_dig_d;
              dig_last_q <= (idx_m1_d == '0);
            end
          end else begin
            state_q <= S_EMIT;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ack       = ack_q;
  assign o_cv_stb    = cv_stb_q;
  assign o_cv_bin    = operand_q;
  assign o_dig       = dig_q;
  assign o_dig_valid = dig_valid_q;
  assign o_dig_last  = dig_last_q;
  assign o_dig_id    = dig_id_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_err       = err_q;

endmodule

// File: tb/tb_bin2dec_sched.sv
// Bench for bin2dec_sched: converter model, requesters and a scoreboard built from
// decimal strings of the latched operands, plus directed scenarios with literal expectations.
module tb_bin2dec_sched;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int MAXD    = 3;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [3:0] d;
    int         id;
    bit         last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [WIDTH-1:0] bin_v [NREQ];
  logic [NREQ*WIDTH-1:0] i_bin;
  logic [NREQ-1:0]  o_ack;
  logic [WIDTH-1:0] o_cv_bin;
  logic             o_cv_stb;
  logic [3:0]       cv_digit = '0;
  logic             cv_dig_rd = 1'b0;
  logic             cv_conv_rd = 1'b0;
  logic [3:0]       o_dig;
  logic             o_dig_valid;
  logic             dig_ready = 1'b0;
  logic             o_dig_last;
  logic [1:0]       o_dig_id;
  logic             o_busy;
  logic             o_err;

  beat_t exp_q[$];
  beat_t log_q[$];
  int    checks = 0;
  int    passes = 0;
  bit    rand_req = 1'b0;
  bit    rand_rdy = 1'b0;
  bit    hang = 1'b0;
  int    ptr_m = 0;
  int    cdig[$];
  bit    c_active = 1'b0;
  bit    c_same = 1'b0;
  bit    c_pend = 1'b0;
  int    c_gaps = 0;

  assign i_bin = {bin_v[3], bin_v[2], bin_v[1], bin_v[0]};

  bin2dec_sched #(
    .WIDTH      (WIDTH),
    .NREQ       (NREQ),
    .MAX_DIGITS (MAXD),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (req),
    .i_bin        (i_bin),
    .o_ack        (o_ack),
    .o_cv_bin     (o_cv_bin),
    .o_cv_stb     (o_cv_stb),
    .i_cv_digit   (cv_digit),
    .i_cv_dig_rd  (cv_dig_rd),
    .i_cv_conv_rd (cv_conv_rd),
    .o_dig        (o_dig),
    .o_dig_valid  (o_dig_valid),
    .i_dig_ready  (dig_ready),
    .o_dig_last   (o_dig_last),
    .o_dig_id     (o_dig_id),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passes++;
  endtask

  // Expected beats of a number: its decimal text, most significant character first.
  function automatic void push_expected(input int id, input int v);
    string s;
    beat_t b;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) begin
      b.d    = 4'(s.getc(i) - 8'd48);
      b.id   = id;
      b.last = (i == s.len() - 1);
      exp_q.push_back(b);
    end
  endfunction

  // Converter, requesters, ready and the per-cycle scoreboard compare.
  initial begin
    int    g;
    int    v;
    beat_t b;
    for (int k = 0; k < NREQ; k++) bin_v[k] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        cdig.delete();
        ptr_m = 0; c_active = 0; c_pend = 0;
        cv_dig_rd = 0; cv_conv_rd = 0; cv_digit = '0;
        continue;
      end
      if (o_ack != '0) begin
        g = -1;
        for (int i = 0; i < NREQ; i++) begin
          v = (ptr_m + i) % NREQ;
          if (g < 0 && req[v]) g = v;
        end
        chk("ack_grant", o_ack, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("cv_stb_with_ack", o_cv_stb, 1);
        if (g >= 0) begin
          chk("cv_bin", o_cv_bin, bin_v[g]);
          if (!hang) push_expected(g, int'(bin_v[g]));
          ptr_m = (g + 1) % NREQ;
        end
        req = req & ~o_ack;
      end else begin
        chk("cv_stb_idle", o_cv_stb, 0);
      end
      cv_dig_rd = 0;
      cv_conv_rd = 0;
      if (c_pend) begin
        cv_conv_rd = 1; c_pend = 0; c_active = 0;
      end else if (c_active) begin
        if (c_gaps < 2 && $urandom_range(0, 3) == 0) begin
          c_gaps++;
        end else begin
          cv_digit  = 4'(cdig.pop_front());
          cv_dig_rd = 1;
          if (cdig.size() == 0) begin
            if (hang) c_active = 0;
            else if (c_same) begin cv_conv_rd = 1; c_active = 0; end
            else c_pend = 1;
          end
        end
      end
      if (o_cv_stb) begin
        v = int'(o_cv_bin);
        cdig.delete();
        do begin cdig.push_back(v % 10); v = v / 10; end while (v != 0);
        c_active = 1; c_pend = 0; c_gaps = 0;
        c_same = ($urandom_range(0, 1) == 1);
      end
      if (rand_req) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!req[k] && $urandom_range(0, 7) == 0) begin
            bin_v[k] = WIDTH'($urandom_range(0, 255));
            req[k] = 1'b1;
          end
        end
      end
      if (rand_rdy) dig_ready = ($urandom_range(0, 3) != 0);
      #2;
      if (o_dig_valid) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("dig", o_dig, exp_q[0].d);
          chk("dig_id", o_dig_id, exp_q[0].id);
          chk("dig_last", o_dig_last, exp_q[0].last);
          if (dig_ready) begin
            b.d = o_dig; b.id = int'(o_dig_id); b.last = o_dig_last;
            log_q.push_back(b);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic set_req(input int k, input int v);
    @(negedge clk);
    #1;
    bin_v[k] = WIDTH'(v);
    req[k] = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (n < budget && !(!o_busy && req == '0 && exp_q.size() == 0 && !o_dig_valid)) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk({name, "_done"}, n < budget, 1);
  endtask

  task automatic wait_ack(input string name, input int k);
    int n = 0;
    while (n < 50 && !o_ack[k]) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_ack"}, o_ack[k], 1);
  endtask

  task automatic check_log(input string tag, input string ds, input string ids, input string ls);
    chk({tag, "_count"}, log_q.size(), ds.len());
    for (int i = 0; i < ds.len() && i < log_q.size(); i++) begin
      chk({tag, "_dig"}, log_q[i].d, ds.getc(i) - 8'd48);
      chk({tag, "_id"}, log_q[i].id, ids.getc(i) - 8'd48);
      chk({tag, "_last"}, log_q[i].last, ls.getc(i) - 8'd48);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_dig_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_stb", o_cv_stb, 0);
    #1 rst_n = 1'b1;
    dig_ready = 1'b1;

    // Simultaneous requests from 1 and 3 with pointer 0, then 1 re-requests.
    log_q.delete();
    @(negedge clk);
    #1;
    bin_v[1] = 8'd13; bin_v[3] = 8'd9;
    req[1] = 1'b1; req[3] = 1'b1;
    wait_ack("t3", 1);
    bin_v[1] = 8'd60;
    req[1] = 1'b1;
    wait_idle("t3", 200);
    check_log("t3", "13960", "11311", "01101");

    log_q.delete();
    set_req(0, 0);
    wait_idle("t1", 60);
    check_log("t1", "0", "0", "1");

    log_q.delete();
    set_req(2, 255);
    wait_idle("t2", 60);
    check_log("t2", "255", "222", "001");
    chk("t2_err", o_err, 0);

    // Consumer stalls on the middle digit of 107.
    log_q.delete();
    dig_ready = 1'b0;
    set_req(0, 107);
    n = 0;
    while (n < 50 && !o_dig_valid) begin @(negedge clk); #1; n++; end
    chk("t4_first", o_dig, 1);
    dig_ready = 1'b1;
    @(negedge clk);
    #1;
    dig_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", o_dig_valid, 1);
      chk("t4_stall_dig", o_dig, 0);
      @(negedge clk);
      #1;
    end
    dig_ready = 1'b1;
    wait_idle("t4", 60);
    check_log("t4", "107", "000", "001");

    // Converter never finishes: timeout, error, no beats.
    log_q.delete();
    hang = 1'b1;
    set_req(3, 200);
    wait_ack("t5", 3);
    n = 0;
    while (n < 200 && !o_err) begin @(negedge clk); #1; n++; end
    chk("t5_err", o_err, 1);
    chk("t5_time_lo", n >= TIMEOUT, 1);
    chk("t5_time_hi", n <= TIMEOUT + 4, 1);
    repeat (3) @(negedge clk);
    chk("t5_idle", o_busy, 0);
    chk("t5_no_beats", log_q.size(), 0);
    hang = 1'b0;

    // Reset while collecting aborts the conversion.
    set_req(2, 99);
    wait_ack("t6", 2);
    @(negedge clk);
    #1;
    chk("t6_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    req = '0;
    #1;
    chk("t6_busy_rst", o_busy, 0);
    chk("t6_err_rst", o_err, 0);
    chk("t6_valid_rst", o_dig_valid, 0);
    chk("t6_ack_rst", o_ack, 0);
    chk("t6_stb_rst", o_cv_stb, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    log_q.delete();
    set_req(1, 42);
    wait_idle("t6", 60);
    check_log("t6", "42", "11", "01");

    // Random traffic and backpressure.
    log_q.delete();
    rand_req = 1'b1;
    rand_rdy = 1'b1;
    repeat (3000) @(negedge clk);
    rand_req = 1'b0;
    wait_idle("rand", 600);
    rand_rdy = 1'b0;
    dig_ready = 1'b1;
    chk("rand_err", o_err, 0);
    chk("rand_beats", log_q.size() > 20, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
